// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: in-order FIFO of predicted conditional branches.
// Each entry keeps the predicted direction and the BHR snapshot used to
// index the PHT. Resolving the oldest entry produces a registered training
// strobe and, on a direction mismatch, a registered flush pulse with the
// corrected history. A mispredict squashes every younger entry.
module branch_resolve_queue #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    input  logic [N-1:0]               pred_bhr,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       upd_valid,
    output logic                       upd_taken,
    output logic [N-1:0]               upd_index,
    output logic                       mispredict,
    output logic [N-1:0]               recover_bhr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic          taken_mem_r [DEPTH];
    logic [N-1:0]  bhr_mem_r   [DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic [PW-1:0] head_nxt_s;
    logic [PW-1:0] tail_nxt_s;
    logic [CW-1:0] count_nxt_s;

    logic          enq_fire_s;
    logic          res_fire_s;
    logic          mis_s;
    logic          head_taken_s;
    logic [N-1:0]  head_bhr_s;

    logic          upd_valid_r;
    logic          upd_taken_r;
    logic [N-1:0]  upd_index_r;
    logic          mispredict_r;
    logic [N-1:0]  recover_bhr_r;

    // Handshakes come only from the registered occupancy, so a full queue
    // stays closed even when a resolve frees a slot in the same cycle.
    assign pred_ready   = (count_r != FULL_COUNT);
    assign res_ready    = (count_r != {CW{1'b0}});
    assign enq_fire_s   = pred_valid && pred_ready;
    assign res_fire_s   = res_valid && res_ready;
    assign head_taken_s = taken_mem_r[head_r];
    assign head_bhr_s   = bhr_mem_r[head_r];
    assign mis_s        = res_fire_s && (res_taken != head_taken_s);

    // Next pointer/occupancy: a mispredict empties the queue and drops any enqueue.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (mis_s) begin
            head_nxt_s  = {PW{1'b0}};
            tail_nxt_s  = {PW{1'b0}};
            count_nxt_s = {CW{1'b0}};
        end else begin
            if (enq_fire_s) begin
                tail_nxt_s = tail_r + PW'(1);
            end else begin
                tail_nxt_s = tail_r;
            end
            if (res_fire_s) begin
                head_nxt_s = head_r + PW'(1);
            end else begin
                head_nxt_s = head_r;
            end
            if (enq_fire_s && !res_fire_s) begin
                count_nxt_s = count_r + CW'(1);
            end else if (res_fire_s && !enq_fire_s) begin
                count_nxt_s = count_r - CW'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (enq_fire_s && !mis_s && !reset) begin
            taken_mem_r[tail_r] <= pred_taken;
            bhr_mem_r[tail_r]   <= pred_bhr;
        end
    end

    // Registered training/redirect outputs; index and history hold between resolves.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_r   <= 1'b0;
            upd_taken_r   <= 1'b0;
            upd_index_r   <= {N{1'b0}};
            mispredict_r  <= 1'b0;
            recover_bhr_r <= {N{1'b0}};
        end else begin
            upd_valid_r  <= res_fire_s;
            mispredict_r <= mis_s;
            if (res_fire_s) begin
                upd_taken_r   <= res_taken;
                upd_index_r   <= head_bhr_s;
                recover_bhr_r <= {head_bhr_s[N-2:0], res_taken};
            end
        end
    end

    assign upd_valid   = upd_valid_r;
    assign upd_taken   = upd_taken_r;
    assign upd_index   = upd_index_r;
    assign mispredict  = mispredict_r;
    assign recover_bhr = recover_bhr_r;
    assign count       = count_r;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter N, default 4: global branch history width; equals the predictor's BHR width.
REQ-002 Parameter DEPTH, default 4: in-flight branch entries; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 pred_valid  input  1  fetch presents a predicted conditional branch.
REQ-006 pred_taken  input  1  direction the predictor gave for that branch.
REQ-007 pred_bhr  input  N  BHR snapshot that indexed the PHT for that prediction.
REQ-008 pred_ready  output  1  queue accepts an enqueue this cycle.
REQ-009 res_valid  input  1  execute resolves the oldest in-flight branch.
REQ-010 res_taken  input  1  actual outcome of that branch.
REQ-011 res_ready  output  1  an entry is available to resolve.
REQ-012 upd_valid  output  1  registered predictor-training strobe.
REQ-013 upd_taken  output  1  actual outcome to train with.
REQ-014 upd_index  output  N  PHT index (the stored snapshot) to train.
REQ-015 mispredict  output  1  registered one-cycle flush/redirect pulse.
REQ-016 recover_bhr  output  N  corrected history = {snapshot[N-2:0], actual outcome}.
REQ-017 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-018 The block SHALL be a circular FIFO of DEPTH entries {taken, bhr}, with head/tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 pred_ready SHALL equal (count != DEPTH); res_ready SHALL equal (count != 0); both depend on registered count only, with no same-cycle bypass.
REQ-020 Enqueue fires when pred_valid && pred_ready: write entry at tail, tail+1.
REQ-021 Resolve fires when res_valid && res_ready: read entry at head, head+1; res_valid while empty SHALL be ignored with no output activity.
REQ-022 On each resolve, the following cycle SHALL have upd_valid=1, upd_taken=res_taken, upd_index=stored bhr; otherwise upd_valid=0.
REQ-023 If res_taken != stored taken, the following cycle SHALL also have mispredict=1 and recover_bhr={stored bhr[N-2:0], res_taken}; otherwise mispredict=0.
REQ-024 upd_index and recover_bhr SHALL hold their last values while upd_valid=0.
REQ-025 Mispredicting resolve: at the same edge, head, tail and count SHALL be reset to 0 (squash all younger entries), and any simultaneous enqueue SHALL be dropped.
REQ-026 Correct resolve with simultaneous enqueue: count unchanged; both pointers advance.
REQ-027 Full queue: enqueue blocked even if a resolve fires the same cycle; slot becomes available the next cycle.
REQ-028 count SHALL increment on enqueue-only, decrement on resolve-only, and never exceed DEPTH or drop below 0.
REQ-029 Resolution is strictly in program order; there is no out-of-order tag.

Reset
REQ-030 reset=1 at an edge SHALL clear head, tail, count, upd_valid, mispredict, upd_taken, upd_index and recover_bhr to 0; entry storage need not be cleared.
REQ-031 reset SHALL override any simultaneous enqueue or resolve, including a mispredict in progress; the cycle after reset releases, pred_ready=1 and res_ready=0.

Verification
REQ-032 N=4: enqueue (taken=1, bhr=0101), resolve taken=1 -> next cycle upd_valid=1, upd_taken=1, upd_index=0101, mispredict=0, count=0.
REQ-033 Enqueue (taken=0, bhr=0011), then (1, 1000), (1, 1111); resolve taken=1 -> mispredict=1, recover_bhr=0111, upd_index=0011; count=0 next cycle; subsequent res_valid ignored.
REQ-034 Fill with 4 entries -> pred_ready=0, count=4; fifth pred_valid with simultaneous correct resolve -> not accepted, count=3, pred_ready=1 next cycle.
REQ-035 Push/pop 10 branches with mixed correct outcomes and one in flight at a time -> pointers wrap cleanly; upd_index sequence matches enqueue order; no mispredict.
REQ-036 Mispredicting resolve plus simultaneous enqueue -> enqueue dropped, count=0; reset asserted with 2 entries queued -> count=0, upd_valid=0, mispredict=0 next cycle.
